// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 16x16 register file: round-robin grant between the
// ALU pipe (A) and the long-latency unit (B), registered write port, bypass flags.
module rf_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              hlt,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst,
    output logic              we,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              byp0,
    output logic              byp1,
    output logic [DATA_W-1:0] byp_data,
    output logic [15:0]       conflict_cnt,
    output logic              pri_dbg
);

    // Handshake: a write moves when x_valid && x_ready in the same cycle; the
    // requester holds valid/addr/data stable until it sees ready. Ready depends
    // only on valid, hlt, rst and the priority pointer, never on addr/data.

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t pri_q;
    pri_t pri_d;
    logic denied;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        pri_d   = pri_q;
        if (!rst && !hlt) begin
            if (a_valid && (!b_valid || pri_q == PRI_A)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
        // The winner yields priority to the other side for the next contest.
        if (a_ready) begin
            pri_d = PRI_B;
        end else if (b_ready) begin
            pri_d = PRI_A;
        end
    end

    assign denied = (a_valid && !a_ready) || (b_valid && !b_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q <= PRI_A;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Register-0 writes are consumed here but never raise we.
    always_ff @(posedge clk) begin
        if (rst) begin
            we       <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
        end else if (a_ready) begin
            we       <= (a_addr != '0);
            dst_addr <= a_addr;
            dst      <= a_data;
        end else if (b_ready) begin
            we       <= (b_addr != '0);
            dst_addr <= b_addr;
            dst      <= b_data;
        end else begin
            we       <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (denied && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign byp0     = we && (dst_addr == rd0_addr);
    assign byp1     = we && (dst_addr == rd1_addr);
    assign byp_data = dst;
    assign pri_dbg  = (pri_q == PRI_B);

endmodule
